exec_unit_p: RTL and testbench

EXEC_UNIT_P -- requirements
Module: exec_unit_p

---
 rtl/exec_unit_p.sv | 157 +++++++++++++++
 tb/tb_exec_unit_p.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_p.sv
// exec_unit_p: execute unit with register file, data memory and branch redirect.
// Define EXEC_UNIT_P_MUL_EN to add a two-cycle MUL (opcode 01, funct3 101).
module exec_unit_p #(
    parameter int DATA_W     = 16,
    parameter int REG_N      = 8,
    parameter int DMEM_DEPTH = 256,
    parameter int IMM_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        pc,
    input  logic [1:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [$clog2(REG_N)-1:0] rd,
    input  logic [$clog2(REG_N)-1:0] rs1,
    input  logic [$clog2(REG_N)-1:0] rs2,
    input  logic [IMM_W-1:0]         imm,
    output logic                     jump,
    output logic [DATA_W-1:0]        pc_jump,
    output logic                     retire,
    input  logic [$clog2(REG_N)-1:0] dbg_sel,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int RW = $clog2(REG_N);
    localparam int AW = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, MUL1, MUL2} state_t;

    state_t            state;
    logic [DATA_W-1:0] rf  [REG_N];
    logic [DATA_W-1:0] mem [DMEM_DEPTH];
    logic [RW-1:0]     wb_rd;
    logic [AW-1:0]     ld_addr;
`ifdef EXEC_UNIT_P_MUL_EN
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
`endif

    logic              accept;
    logic [DATA_W-1:0] imm_x;
    logic [DATA_W-1:0] imm_hi;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] dst;
    logic [DATA_W-1:0] pc_rel;
    logic [DATA_W-1:0] pc_inc;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign imm_x    = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign imm_hi   = {imm, {(DATA_W-IMM_W){1'b0}}};
    assign src1     = rf[rs1];
    assign src2     = rf[rs2];
    assign dst      = rf[rd];
    assign pc_rel   = pc + imm_x;
    assign pc_inc   = pc + {{(DATA_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            jump     <= 1'b0;
            pc_jump  <= '0;
            retire   <= 1'b0;
            dbg_data <= '0;
            wb_rd    <= '0;
            ld_addr  <= '0;
`ifdef EXEC_UNIT_P_MUL_EN
            mul_a    <= '0;
            mul_b    <= '0;
`endif
            for (int i = 0; i < REG_N; i++) rf[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            jump     <= 1'b0;
            retire   <= 1'b0;
            dbg_data <= rf[dbg_sel];
            case (state)
                IDLE: if (accept) begin
                    // Single-cycle ops retire now; LW/MUL clear this below.
                    retire <= 1'b1;
                    case ({opcode, funct3})
                        5'b00_001: mem[imm[AW-1:0]] <= src1;
                        5'b00_010: begin
                            retire  <= 1'b0;
                            wb_rd   <= rd;
                            ld_addr <= imm[AW-1:0];
                            state   <= LOAD;
                        end
                        5'b01_000: rf[rd] <= src1 + src2;
                        5'b01_001: rf[rd] <= src1 - src2;
                        5'b01_010: rf[rd] <= src1 & src2;
                        5'b01_011: rf[rd] <= src1 | src2;
                        5'b01_100: rf[rd] <= src1 ^ src2;
`ifdef EXEC_UNIT_P_MUL_EN
                        5'b01_101: begin
                            retire <= 1'b0;
                            wb_rd  <= rd;
                            mul_a  <= src1;
                            mul_b  <= src2;
                            state  <= MUL1;
                        end
`endif
                        5'b10_000: rf[rd] <= dst + imm_x;
                        5'b10_001: rf[rd] <= imm_x;
                        5'b10_010: rf[rd] <= imm_hi;
                        5'b11_000: if (dst == '0) begin
                            jump    <= 1'b1;
                            pc_jump <= pc_rel;
                        end
                        5'b11_001: if (dst != '0) begin
                            jump    <= 1'b1;
                            pc_jump <= pc_rel;
                        end
                        5'b11_010: begin
                            jump    <= 1'b1;
                            pc_jump <= pc_rel;
                        end
                        5'b11_011: begin
                            rf[rd]  <= pc_inc;
                            jump    <= 1'b1;
                            pc_jump <= pc_rel;
                        end
                        5'b11_100: begin
                            jump    <= 1'b1;
                            pc_jump <= dst;
                        end
                        5'b11_101: begin
                            // src1 is the pre-edge value, so rd==rs1 still jumps to the old R[rs1].
                            rf[rd]  <= pc_inc;
                            jump    <= 1'b1;
                            pc_jump <= src1;
                        end
                        default: ;
                    endcase
                end
                LOAD: begin
                    rf[wb_rd] <= mem[ld_addr];
                    retire    <= 1'b1;
                    state     <= IDLE;
                end
`ifdef EXEC_UNIT_P_MUL_EN
                MUL1: state <= MUL2;
                MUL2: begin
                    rf[wb_rd] <= mul_a * mul_b;
                    retire    <= 1'b1;
                    state     <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit_p.sv
// Self-checking bench for exec_unit_p: directed scenarios plus a random
// instruction stream compared every cycle against an instruction-level model.
module tb_exec_unit_p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] pc = '0;
    logic [1:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [2:0]  rd = '0;
    logic [2:0]  rs1 = '0;
    logic [2:0]  rs2 = '0;
    logic [7:0]  imm = '0;
    logic        jump;
    logic [15:0] pc_jump;
    logic        retire;
    logic [2:0]  dbg_sel = '0;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int retire_cnt = 0;
    int notready_cnt = 0;
    int jump_cnt = 0;

    always #5 clk = ~clk;

    exec_unit_p dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .opcode(opcode), .funct3(funct3),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .jump(jump), .pc_jump(pc_jump), .retire(retire),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    function automatic void chk1(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void chk16(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void chkn(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    // Instruction-level reference model: architectural state plus a count
    // of edges until an outstanding LW/MUL result lands.
    logic [15:0] mR [8];
    logic [15:0] mM [256];
    int          busy = 0;
    logic [2:0]  prd = '0;
    logic [15:0] pval = '0;
    logic        e_ready = 1'b1;
    logic        e_retire = 1'b0;
    logic        e_jump = 1'b0;
    logic [15:0] e_pcj = '0;
    logic [15:0] e_dbg = '0;

    task automatic take(input logic [15:0] t);
        e_jump = 1'b1;
        e_pcj  = t;
    endtask

    task automatic model_exec();
        logic [15:0] a, b, d, ix, rel, link;
        logic [31:0] prod;
        a    = mR[rs1];
        b    = mR[rs2];
        d    = mR[rd];
        ix   = {8'h00, imm};
        rel  = pc + ix;
        link = pc + 16'd1;
        prod = '0;
        e_retire = 1'b1;
        case (opcode)
            2'd0: begin
                if (funct3 == 3'd1) mM[imm] = a;
                else if (funct3 == 3'd2) begin
                    busy = 1; prd = rd; pval = mM[imm]; e_retire = 1'b0;
                end
            end
            2'd1: begin
                case (funct3)
                    3'd0: mR[rd] = a + b;
                    3'd1: mR[rd] = a - b;
                    3'd2: mR[rd] = a & b;
                    3'd3: mR[rd] = a | b;
                    3'd4: mR[rd] = a ^ b;
`ifdef EXEC_UNIT_P_MUL_EN
                    3'd5: begin
                        prod = {16'h0, a} * {16'h0, b};
                        busy = 2; prd = rd; pval = prod[15:0]; e_retire = 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
            2'd2: begin
                case (funct3)
                    3'd0: mR[rd] = d + ix;
                    3'd1: mR[rd] = ix;
                    3'd2: mR[rd] = ix * 16'd256;
                    default: ;
                endcase
            end
            default: begin
                case (funct3)
                    3'd0: if (d == 16'd0) take(rel);
                    3'd1: if (d != 16'd0) take(rel);
                    3'd2: take(rel);
                    3'd3: begin mR[rd] = link; take(rel); end
                    3'd4: take(d);
                    3'd5: begin mR[rd] = link; take(a); end
                    default: ;
                endcase
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            foreach (mR[i]) mR[i] = '0;
            foreach (mM[i]) mM[i] = '0;
            busy = 0;
            e_ready = 1'b1; e_retire = 1'b0; e_jump = 1'b0;
            e_pcj = '0; e_dbg = '0;
        end else begin
            e_dbg = mR[dbg_sel];
            e_retire = 1'b0;
            e_jump = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    mR[prd] = pval;
                    e_retire = 1'b1;
                end
            end else if (in_valid) begin
                model_exec();
            end
            e_ready = (busy == 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk1("in_ready", in_ready, e_ready);
            chk1("retire", retire, e_retire);
            chk1("jump", jump, e_jump);
            chk16("pc_jump", pc_jump, e_pcj);
            chk16("dbg_data", dbg_data, e_dbg);
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            retire_cnt   += int'(retire);
            jump_cnt     += int'(jump);
            notready_cnt += int'(!in_ready);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] f3,
                         input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [7:0] im,
                         input logic [15:0] p);
        int n;
        opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2;
        imm = im; pc = p; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk1("issue_timeout", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk1("idle_timeout", in_ready, 1'b1);
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [15:0] v);
        dbg_sel = idx;
        @(negedge clk);
        v = dbg_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int r0, n0, j0;
        logic [1:0] op;
        logic [2:0] f3;
        logic [7:0] im;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_retire", retire, 1'b0);
        chk1("rst_jump", jump, 1'b0);
        chk16("rst_pc_jump", pc_jump, 16'h0000);
        chk16("rst_dbg", dbg_data, 16'h0000);

        // LI / LI / SUB
        r0 = retire_cnt; n0 = notready_cnt;
        issue(2'b10, 3'b001, 3'd1, 3'd0, 3'd0, 8'h05, 16'h0);
        issue(2'b10, 3'b001, 3'd2, 3'd0, 3'd0, 8'h03, 16'h0);
        issue(2'b01, 3'b001, 3'd3, 3'd1, 3'd2, 8'h00, 16'h0);
        read_reg(3'd3, v);
        chk16("sub_r3", v, 16'h0002);
        chk16("model_r3", mR[3], 16'h0002);
        chkn("sub_retires", retire_cnt - r0, 3);
        chkn("sub_ready_low", notready_cnt - n0, 0);

        // SW then LW through memory
        issue(2'b10, 3'b001, 3'd1, 3'd0, 3'd0, 8'hAB, 16'h0);
        issue(2'b00, 3'b001, 3'd0, 3'd1, 3'd0, 8'h10, 16'h0);
        r0 = retire_cnt; n0 = notready_cnt;
        issue(2'b00, 3'b010, 3'd4, 3'd0, 3'd0, 8'h10, 16'h0);
        wait_idle();
        read_reg(3'd4, v);
        chk16("lw_r4", v, 16'h00AB);
        chkn("lw_retires", retire_cnt - r0, 1);
        chkn("lw_ready_low", notready_cnt - n0, 1);

        // LUI / ADDI and wrap
        issue(2'b10, 3'b010, 3'd5, 3'd0, 3'd0, 8'h12, 16'h0);
        issue(2'b10, 3'b000, 3'd5, 3'd0, 3'd0, 8'hFF, 16'h0);
        read_reg(3'd5, v);
        chk16("lui_addi_r5", v, 16'h12FF);
        issue(2'b10, 3'b010, 3'd6, 3'd0, 3'd0, 8'hFF, 16'h0);
        issue(2'b10, 3'b000, 3'd6, 3'd0, 3'd0, 8'hFF, 16'h0);
        read_reg(3'd6, v);
        chk16("r6_ffff", v, 16'hFFFF);
        issue(2'b10, 3'b000, 3'd6, 3'd0, 3'd0, 8'h01, 16'h0);
        read_reg(3'd6, v);
        chk16("addi_wrap_r6", v, 16'h0000);

        // Branches and JALR with rd==rs1
        issue(2'b10, 3'b001, 3'd2, 3'd0, 3'd0, 8'h00, 16'h0);
        j0 = jump_cnt;
        issue(2'b11, 3'b000, 3'd2, 3'd0, 3'd0, 8'h08, 16'h0040);
        chk1("beqz_jump", jump, 1'b1);
        chk16("beqz_target", pc_jump, 16'h0048);
        issue(2'b11, 3'b001, 3'd2, 3'd0, 3'd0, 8'h08, 16'h0040);
        chk1("bnez_jump", jump, 1'b0);
        chk16("bnez_hold", pc_jump, 16'h0048);
        chkn("branch_pulses", jump_cnt - j0, 1);
        issue(2'b10, 3'b010, 3'd3, 3'd0, 3'd0, 8'h01, 16'h0);
        issue(2'b11, 3'b101, 3'd3, 3'd3, 3'd0, 8'h00, 16'h0050);
        chk1("jalr_jump", jump, 1'b1);
        chk16("jalr_target", pc_jump, 16'h0100);
        read_reg(3'd3, v);
        chk16("jalr_link", v, 16'h0051);

        // MUL, or NOP when the multiplier is not built
        issue(2'b10, 3'b010, 3'd1, 3'd0, 3'd0, 8'h01, 16'h0);
        issue(2'b10, 3'b000, 3'd1, 3'd0, 3'd0, 8'h02, 16'h0);
        issue(2'b10, 3'b010, 3'd2, 3'd0, 3'd0, 8'h01, 16'h0);
`ifdef EXEC_UNIT_P_MUL_EN
        r0 = retire_cnt; n0 = notready_cnt;
        issue(2'b01, 3'b101, 3'd3, 3'd1, 3'd2, 8'h00, 16'h0);
        wait_idle();
        read_reg(3'd3, v);
        chk16("mul_r3", v, 16'h0200);
        chkn("mul_ready_low", notready_cnt - n0, 2);
        chkn("mul_retires", retire_cnt - r0, 1);
        r0 = retire_cnt;
        issue(2'b01, 3'b101, 3'd3, 3'd1, 3'd2, 8'h00, 16'h0);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk1("abort_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        read_reg(3'd3, v);
        chk16("abort_r3", v, 16'h0000);
        chkn("abort_retires", retire_cnt - r0, 0);
`else
        issue(2'b10, 3'b001, 3'd3, 3'd0, 3'd0, 8'h07, 16'h0);
        r0 = retire_cnt; n0 = notready_cnt;
        issue(2'b01, 3'b101, 3'd3, 3'd1, 3'd2, 8'h00, 16'h0);
        read_reg(3'd3, v);
        chk16("mul_nop_r3", v, 16'h0007);
        chkn("mul_nop_retires", retire_cnt - r0, 1);
        chkn("mul_nop_ready_low", notready_cnt - n0, 0);
`endif

        // Random stream against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                dbg_sel = 3'($urandom);
                @(negedge clk);
            end
            op = 2'($urandom);
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            im = (op == 2'd0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            dbg_sel = 3'($urandom);
            issue(op, f3, 3'($urandom), 3'($urandom), 3'($urandom), im, 16'($urandom));
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
